pc_fetch_unit: RTL

Program-counter and instruction-fetch stage of the single-issue CPU. Holds the architectural PC and fetches from instruction memory through the busywait handshake. Presents the fetched instruction to decode. It consumes the branch/jump adder's gated offset (zero when not taken) and forms the next PC as PC+4+offset once the instruction retires.

---
 rtl/cpu_pkg.sv | 22 ++
 rtl/pc_fetch_unit_if.sv | 26 ++
 rtl/pc_next_calc.sv | 16 +
 rtl/pc_fetch_unit.sv | 103 ++++++++++
 4 files changed

// File: rtl/cpu_pkg.sv
// Shared CPU definitions: word width, instruction word type, fetch FSM
// states and the default reset PC. Imported by the fetch-stage files.
package cpu_pkg;

    localparam int WORD_W = 32;

    typedef logic [WORD_W-1:0] word_t;
    typedef word_t             instr_t;

    // Default architectural PC after reset; must be word-aligned.
    localparam word_t RESET_PC_DEFAULT = 32'h0000_0000;

    // Clears bits [1:0] so every computed PC lands on a word boundary.
    localparam word_t WORD_ALIGN_MASK = ~word_t'(3);

    typedef enum logic [1:0] {
        HOLD  = 2'd0,
        FETCH = 2'd1,
        EXEC  = 2'd2
    } fetch_state_e;

endpackage

// File: rtl/pc_fetch_unit_if.sv
// Instruction-memory handshake bundle. The fetch unit is the master
// (drives the request and address); the memory is the slave (returns the
// word and the busywait stall).
interface pc_fetch_unit_if;
    import cpu_pkg::*;

    logic   imem_read;
    word_t  imem_addr;
    instr_t imem_rdata;
    logic   imem_busywait;

    modport master (
        output imem_read,
        output imem_addr,
        input  imem_rdata,
        input  imem_busywait
    );

    modport slave (
        input  imem_read,
        input  imem_addr,
        output imem_rdata,
        output imem_busywait
    );

endinterface

// File: rtl/pc_next_calc.sv
// Combinational next-PC arithmetic: PC+4 for the sequential successor and
// the aligned retire target PC+4+offset. All sums wrap mod 2^32, so a
// two's-complement offset gives a backward branch.
module pc_next_calc
    import cpu_pkg::*;
(
    input  word_t pc_i,
    input  word_t branch_offset_i,
    output word_t pc_plus4_o,
    output word_t pc_next_o
);

    assign pc_plus4_o = pc_i + word_t'(4);
    assign pc_next_o  = (pc_plus4_o + branch_offset_i) & WORD_ALIGN_MASK;

endmodule

// File: rtl/pc_fetch_unit.sv
// Program-counter and instruction-fetch stage. Alternates FETCH (request
// the word at PC until the memory stops stalling) and EXEC (present the
// word to decode until data memory lets it retire), then advances the PC.
// Optional build macro: PC_RETIRE_COUNT_EN adds a retired-instruction
// counter on retired_o.
module pc_fetch_unit
    import cpu_pkg::*;
#(
    parameter word_t RESET_PC = RESET_PC_DEFAULT
) (
    input  logic                   clk,
    input  logic                   rst,
    pc_fetch_unit_if.master        imem,
    input  word_t                  branch_offset_i,
    input  logic                   dmem_busywait_i,
    output word_t                  pc_o,
    output word_t                  pc_plus4_o,
    output instr_t                 instr_o,
    output logic                   instr_valid_o
`ifdef PC_RETIRE_COUNT_EN
    ,
    output word_t                  retired_o
`endif
);

    fetch_state_e state_q;
    word_t        pc_q;
    word_t        pc_next_d;
    instr_t       instr_q;
    logic         imem_read_q;
    logic         instr_valid_q;
`ifdef PC_RETIRE_COUNT_EN
    word_t        retired_q;
`endif

    pc_next_calc u_pc_next_calc (
        .pc_i            (pc_q),
        .branch_offset_i (branch_offset_i),
        .pc_plus4_o      (pc_plus4_o),
        .pc_next_o       (pc_next_d)
    );

    // Fetch FSM with registered handshake outputs, PC and instruction registers.
    // NOTE: the reset branch sits in the sensitivity list, so reset clears
    // every register (and drops imem_read) immediately, not at the next edge.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q       <= HOLD;
            pc_q          <= RESET_PC;
            instr_q       <= '0;
            imem_read_q   <= 1'b0;
            instr_valid_q <= 1'b0;
`ifdef PC_RETIRE_COUNT_EN
            retired_q     <= '0;
`endif
        end else begin
            // NOTE: non-blocking assignments so every register here sees the
            // pre-edge value of the others, regardless of statement order.
            case (state_q)
                HOLD: begin
                    state_q     <= FETCH;
                    imem_read_q <= 1'b1;
                end
                FETCH: begin
                    if (!imem.imem_busywait) begin
                        instr_q       <= imem.imem_rdata;
                        state_q       <= EXEC;
                        imem_read_q   <= 1'b0;
                        instr_valid_q <= 1'b1;
                    end
                end
                EXEC: begin
                    if (!dmem_busywait_i) begin
                        pc_q          <= pc_next_d;
                        state_q       <= FETCH;
                        imem_read_q   <= 1'b1;
                        instr_valid_q <= 1'b0;
`ifdef PC_RETIRE_COUNT_EN
                        retired_q     <= retired_q + word_t'(1);
`endif
                    end
                end
                default: begin
                    state_q       <= HOLD;
                    imem_read_q   <= 1'b0;
                    instr_valid_q <= 1'b0;
                end
            endcase
        end
    end

    // The fetch address is the PC register itself, so it is stable for the
    // whole request (PC only moves on retire, when imem_read is low).
    assign imem.imem_read = imem_read_q;
    assign imem.imem_addr = pc_q;
    assign pc_o           = pc_q;
    assign instr_o        = instr_q;
    assign instr_valid_o  = instr_valid_q;
`ifdef PC_RETIRE_COUNT_EN
    assign retired_o      = retired_q;
`endif

endmodule
